// File: rtl/dispatch.sv
`default_nettype none
// ============================================================================
// Package : types_pkg
// Purpose : Shared uop record passed from rename through dispatch.
// Revision: 1.0 - initial release
// ============================================================================
package types_pkg;
  localparam int PREG_IDX_W = 7;

  typedef struct packed {
    logic [1:0]            fu;      // 0/3 ALU, 1 LSU, 2 branch
    logic [PREG_IDX_W-1:0] pd_new;  // destination preg (0 = none)
    logic [PREG_IDX_W-1:0] pd_old;  // previous mapping, freed at commit
    logic [PREG_IDX_W-1:0] ps1;     // source 1 preg
    logic [PREG_IDX_W-1:0] ps2;     // source 2 preg
    logic [31:0]           imm;     // immediate / opaque payload
  } rename_data;
endpackage

// ============================================================================
// Module  : dispatch
// Purpose : Buffers renamed uops in a 2-entry FIFO, allocates a ROB entry and
//           steers the head uop to the ALU, LSU or branch issue queue. Owns the
//           physical-register busy table and produces source-ready bits.
// Ports   : clk, reset (async active-low)
//           valid_in/data_in/ready_in   - uop handshake from rename
//           rob_full/rob_alloc/rob_data - ROB allocation
//           {alu,lsu,br}_valid/_ready   - issue-queue handshakes
//           iss_data, iss_ps1_rdy, iss_ps2_rdy - shared issue payload
//           wb_valid/wb_pd              - writeback broadcast
//           mispredict                  - flush
// Revision: 1.0 - initial release
// ============================================================================
module dispatch #(
  parameter int PREG_COUNT = 128,
  parameter int PREG_W     = 7,
  parameter int DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_in,
  input  types_pkg::rename_data data_in,
  output logic                  ready_in,
  input  logic                  rob_full,
  output logic                  rob_alloc,
  output types_pkg::rename_data rob_data,
  output logic                  alu_valid,
  input  logic                  alu_ready,
  output logic                  lsu_valid,
  input  logic                  lsu_ready,
  output logic                  br_valid,
  input  logic                  br_ready,
  output types_pkg::rename_data iss_data,
  output logic                  iss_ps1_rdy,
  output logic                  iss_ps2_rdy,
  input  logic                  wb_valid,
  input  logic [PREG_W-1:0]     wb_pd,
  input  logic                  mispredict
);

  types_pkg::rename_data mem_q [DEPTH];
  logic                  head_q;
  logic [1:0]            count_q;
  logic [1:0]            count_d;
  logic [PREG_COUNT-1:0] busy_q;
  logic [PREG_COUNT-1:0] busy_d;

  types_pkg::rename_data head;
  logic                  head_valid;
  logic                  offer;
  logic                  fire;
  logic                  enq;
  logic                  tail;

  always_comb begin
    head_valid = (count_q != 2'd0);
    head       = head_valid ? mem_q[head_q] : '0;
    // ready_in depends only on registered occupancy, never on downstream readies.
    ready_in   = (count_q < 2'(DEPTH));
    offer      = head_valid && !rob_full && !mispredict;

    alu_valid = 1'b0;
    lsu_valid = 1'b0;
    br_valid  = 1'b0;
    case (head.fu)
      2'd1:    lsu_valid = offer;
      2'd2:    br_valid  = offer;
      default: alu_valid = offer;
    endcase

    fire      = (alu_valid && alu_ready) || (lsu_valid && lsu_ready) ||
                (br_valid && br_ready);
    rob_alloc = fire;
    rob_data  = head;
    iss_data  = head;

    enq     = valid_in && ready_in && !mispredict;
    // With one entry the free slot is the one opposite the head; with none it is the head slot.
    tail    = head_q ^ count_q[0];
    count_d = count_q + {1'b0, enq} - {1'b0, fire};

    // Same-cycle writeback is forwarded so a uop is not held back by a stale busy bit.
    iss_ps1_rdy = (head.ps1 == '0) || !busy_q[head.ps1] || (wb_valid && (wb_pd == head.ps1));
    iss_ps2_rdy = (head.ps2 == '0) || !busy_q[head.ps2] || (wb_valid && (wb_pd == head.ps2));

    // Clear first, then set, so a simultaneous allocate of the same preg wins.
    busy_d = busy_q;
    if (wb_valid) begin
      busy_d[wb_pd] = 1'b0;
    end
    if (fire && (head.pd_new != '0)) begin
      busy_d[head.pd_new] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      head_q  <= 1'b0;
      count_q <= 2'd0;
      busy_q  <= '0;
    end else begin
      // The busy table is left alone by a flush; only writeback and fire touch it.
      busy_q <= busy_d;
      if (mispredict) begin
        head_q  <= 1'b0;
        count_q <= 2'd0;
      end else begin
        if (enq) begin
          mem_q[tail] <= data_in;
        end
        if (fire) begin
          head_q <= ~head_q;
        end
        count_q <= count_d;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dispatch.sv
`default_nettype none
// ============================================================================
// Module  : tb_dispatch
// Purpose : Self-checking bench for dispatch: directed scenarios followed by
//           randomized traffic compared against a queue-based reference model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_dispatch;
  import types_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       valid_in;
  rename_data data_in;
  logic       ready_in;
  logic       rob_full;
  logic       rob_alloc;
  rename_data rob_data;
  logic       alu_valid, alu_ready;
  logic       lsu_valid, lsu_ready;
  logic       br_valid, br_ready;
  rename_data iss_data;
  logic       iss_ps1_rdy, iss_ps2_rdy;
  logic       wb_valid;
  logic [6:0] wb_pd;
  logic       mispredict;

  int checks = 0;
  int errors = 0;

  dispatch #(.PREG_COUNT(128), .PREG_W(7), .DEPTH(2)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .data_in(data_in),
    .ready_in(ready_in), .rob_full(rob_full), .rob_alloc(rob_alloc),
    .rob_data(rob_data), .alu_valid(alu_valid), .alu_ready(alu_ready),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .br_valid(br_valid),
    .br_ready(br_ready), .iss_data(iss_data), .iss_ps1_rdy(iss_ps1_rdy),
    .iss_ps2_rdy(iss_ps2_rdy), .wb_valid(wb_valid), .wb_pd(wb_pd),
    .mispredict(mispredict)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  rename_data mq[$];
  bit         busy_m [128];
  rename_data e_data;
  bit e_ready_in, e_alu_v, e_lsu_v, e_br_v, e_fire, e_ps1, e_ps2;

  task automatic model_clear();
    mq.delete();
    for (int i = 0; i < 128; i++) busy_m[i] = 0;
  endtask

  task automatic model_eval();
    rename_data h;
    bit tv;
    h = (mq.size() > 0) ? mq[0] : '0;
    e_data     = h;
    e_ready_in = (mq.size() < 2);
    tv         = (mq.size() > 0) && !rob_full && !mispredict;
    e_alu_v    = tv && (h.fu == 2'd0 || h.fu == 2'd3);
    e_lsu_v    = tv && (h.fu == 2'd1);
    e_br_v     = tv && (h.fu == 2'd2);
    e_fire     = (e_alu_v && alu_ready) || (e_lsu_v && lsu_ready) || (e_br_v && br_ready);
    e_ps1      = (h.ps1 == 0) || !busy_m[h.ps1] || (wb_valid && wb_pd == h.ps1);
    e_ps2      = (h.ps2 == 0) || !busy_m[h.ps2] || (wb_valid && wb_pd == h.ps2);
  endtask

  task automatic model_commit();
    bit can_enq;
    can_enq = (mq.size() < 2) && valid_in && !mispredict;
    if (e_fire) void'(mq.pop_front());
    if (wb_valid) busy_m[wb_pd] = 0;
    if (e_fire && e_data.pd_new != 0) busy_m[e_data.pd_new] = 1;
    if (mispredict) mq.delete();
    else if (can_enq) mq.push_back(data_in);
  endtask

  task automatic sample();
    @(negedge clk);
    model_eval();
  endtask

  task automatic next_cycle();
    @(posedge clk);
    model_commit();
    #1;
  endtask

  task automatic idle();
    reset = 1'b1; valid_in = 0; data_in = '0; rob_full = 0;
    alu_ready = 0; lsu_ready = 0; br_ready = 0;
    wb_valid = 0; wb_pd = '0; mispredict = 0;
  endtask

  function automatic rename_data mk(input logic [1:0] fu, input int pd, input int s1, input int s2);
    rename_data u;
    u.fu = fu; u.pd_new = 7'(pd); u.ps1 = 7'(s1); u.ps2 = 7'(s2);
    u.pd_old = 7'($urandom_range(0, 127)); u.imm = $urandom;
    return u;
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    idle(); reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (ready_in !== 1'b1) begin errors++; $display("FAIL reset_ready_in: got %b exp 1", ready_in); end
    checks++; if ({alu_valid, lsu_valid, br_valid, rob_alloc} !== 4'b0) begin errors++;
      $display("FAIL reset_valids: got %b exp 0000", {alu_valid, lsu_valid, br_valid, rob_alloc}); end
    checks++; if (iss_data !== '0 || rob_data !== '0) begin errors++;
      $display("FAIL reset_data: got iss %h rob %h exp 0", iss_data, rob_data); end
    model_clear();
    reset = 1'b1;
  endtask

  task automatic test_alu_basic();
    rename_data u0, u1;
    u0 = mk(2'd0, 10, 3, 0);
    u1 = mk(2'd0, 0, 10, 0);
    valid_in = 1; data_in = u0; alu_ready = 1;
    sample();
    checks++; if (alu_valid !== 1'b0) begin errors++; $display("FAIL alu_empty_valid: got %b exp 0", alu_valid); end
    next_cycle();
    valid_in = 0;
    sample();
    checks++; if ({alu_valid, rob_alloc, iss_ps1_rdy} !== 3'b111) begin errors++;
      $display("FAIL alu_fire: got v/alloc/rdy %b exp 111", {alu_valid, rob_alloc, iss_ps1_rdy}); end
    checks++; if (iss_data !== u0 || rob_data !== u0) begin errors++;
      $display("FAIL alu_data: got %h/%h exp %h", iss_data, rob_data, u0); end
    next_cycle();
    valid_in = 1; data_in = u1; alu_ready = 0;
    sample(); next_cycle();
    valid_in = 0;
    sample();
    checks++; if (iss_ps1_rdy !== 1'b0) begin errors++; $display("FAIL alu_busy10: got rdy %b exp 0", iss_ps1_rdy); end
    checks++; if (rob_alloc !== 1'b0) begin errors++; $display("FAIL alu_hold_alloc: got %b exp 0", rob_alloc); end
    next_cycle();
    alu_ready = 1;
    sample(); next_cycle();
    idle();
  endtask

  task automatic test_backpressure();
    rename_data u1, u2, u3;
    u1 = mk(2'd1, 0, 0, 0); u2 = mk(2'd0, 0, 0, 0); u3 = mk(2'd2, 0, 0, 0);
    valid_in = 1; data_in = u1;
    sample(); next_cycle();
    data_in = u2;
    sample();
    checks++; if (ready_in !== 1'b1) begin errors++; $display("FAIL bp_ready_one: got %b exp 1", ready_in); end
    next_cycle();
    data_in = u3;
    sample();
    checks++; if (ready_in !== 1'b0) begin errors++; $display("FAIL bp_ready_full: got %b exp 0", ready_in); end
    checks++; if ({lsu_valid, rob_alloc} !== 2'b10) begin errors++;
      $display("FAIL bp_lsu_wait: got v/alloc %b exp 10", {lsu_valid, rob_alloc}); end
    next_cycle();
    valid_in = 0; lsu_ready = 1;
    sample();
    checks++; if ({lsu_valid, rob_alloc, iss_data == u1} !== 3'b111) begin errors++;
      $display("FAIL bp_lsu_fire: got v/alloc/data %b exp 111", {lsu_valid, rob_alloc, iss_data == u1}); end
    next_cycle();
    lsu_ready = 0;
    sample();
    checks++; if ({ready_in, alu_valid, lsu_valid} !== 3'b110) begin errors++;
      $display("FAIL bp_after_fire: got ready/alu/lsu %b exp 110", {ready_in, alu_valid, lsu_valid}); end
    checks++; if (iss_data !== u2) begin errors++; $display("FAIL bp_next_head: got %h exp %h", iss_data, u2); end
    next_cycle();
    alu_ready = 1;
    sample(); next_cycle();
    idle();
  endtask

  task automatic test_wb_bypass();
    rename_data ua, ub;
    ua = mk(2'd0, 20, 0, 0); ub = mk(2'd0, 0, 0, 20);
    valid_in = 1; data_in = ua; alu_ready = 1;
    sample(); next_cycle();
    data_in = ub;
    sample(); next_cycle();
    valid_in = 0; alu_ready = 0;
    sample();
    checks++; if (iss_ps2_rdy !== 1'b0 || iss_data !== ub) begin errors++;
      $display("FAIL wb_busy20: got rdy %b data %h exp 0 %h", iss_ps2_rdy, iss_data, ub); end
    next_cycle();
    wb_valid = 1; wb_pd = 7'd20;
    sample();
    checks++; if (iss_ps2_rdy !== 1'b1) begin errors++; $display("FAIL wb_bypass: got %b exp 1", iss_ps2_rdy); end
    next_cycle();
    wb_valid = 0;
    sample();
    checks++; if (iss_ps2_rdy !== 1'b1) begin errors++; $display("FAIL wb_cleared: got %b exp 1", iss_ps2_rdy); end
    next_cycle();
    alu_ready = 1;
    sample(); next_cycle();
    idle();
  endtask

  task automatic test_rob_full();
    rename_data ub;
    int fires;
    ub = mk(2'd2, 0, 0, 0);
    fires = 0;
    rob_full = 1; br_ready = 1; valid_in = 1; data_in = ub;
    sample(); next_cycle();
    valid_in = 0;
    for (int i = 0; i < 2; i++) begin
      sample();
      checks++; if ({br_valid, rob_alloc} !== 2'b00 || iss_data !== ub) begin errors++;
        $display("FAIL robfull_stall: got v/alloc %b data %h exp 00 %h", {br_valid, rob_alloc}, iss_data, ub); end
      next_cycle();
    end
    rob_full = 0;
    for (int i = 0; i < 3; i++) begin
      sample();
      if (br_valid && rob_alloc) fires++;
      next_cycle();
    end
    checks++; if (fires != 1) begin errors++; $display("FAIL robfull_fire_once: got %0d fires exp 1", fires); end
    idle();
  endtask

  task automatic test_mispredict();
    valid_in = 1; data_in = mk(2'd0, 30, 0, 0);
    sample(); next_cycle();
    data_in = mk(2'd1, 0, 0, 0);
    sample(); next_cycle();
    mispredict = 1; alu_ready = 1; lsu_ready = 1; data_in = mk(2'd0, 0, 0, 0);
    sample();
    checks++; if ({alu_valid, lsu_valid, br_valid, rob_alloc} !== 4'b0) begin errors++;
      $display("FAIL mp_no_fire: got %b exp 0000", {alu_valid, lsu_valid, br_valid, rob_alloc}); end
    next_cycle();
    mispredict = 0; valid_in = 0;
    sample();
    checks++; if (ready_in !== 1'b1 || alu_valid !== 1'b0 || iss_data !== '0) begin errors++;
      $display("FAIL mp_flushed: got ready %b alu %b data %h exp 1 0 0", ready_in, alu_valid, iss_data); end
    next_cycle();
    alu_ready = 0; lsu_ready = 0; valid_in = 1; data_in = mk(2'd0, 0, 10, 30);
    sample(); next_cycle();
    valid_in = 0;
    sample();
    checks++; if ({iss_ps1_rdy, iss_ps2_rdy} !== 2'b01) begin errors++;
      $display("FAIL mp_busy_kept: got ps1/ps2 %b exp 01", {iss_ps1_rdy, iss_ps2_rdy}); end
    next_cycle();
    alu_ready = 1;
    sample(); next_cycle();
    idle();
  endtask

  task automatic test_set_wins_and_async_reset();
    valid_in = 1; data_in = mk(2'd0, 5, 0, 0); alu_ready = 1;
    sample(); next_cycle();
    valid_in = 0; wb_valid = 1; wb_pd = 7'd5;
    sample(); next_cycle();
    wb_valid = 0; alu_ready = 0; valid_in = 1; data_in = mk(2'd0, 0, 5, 0);
    sample(); next_cycle();
    data_in = mk(2'd1, 0, 0, 0);
    sample();
    checks++; if (iss_ps1_rdy !== 1'b0) begin errors++; $display("FAIL setwins_busy5: got %b exp 0", iss_ps1_rdy); end
    next_cycle();
    idle();
    alu_ready = 1; lsu_ready = 1;
    #2 reset = 1'b0;
    #1;
    checks++; if ({alu_valid, lsu_valid, br_valid, rob_alloc, ready_in} !== 5'b00001 ||
                  iss_data !== '0 || rob_data !== '0) begin errors++;
      $display("FAIL async_reset: got v %b data %h exp 00001 0",
               {alu_valid, lsu_valid, br_valid, rob_alloc, ready_in}, iss_data); end
    model_clear();
    @(negedge clk); reset = 1'b1;
    model_eval();
    next_cycle();
    alu_ready = 0; valid_in = 1; data_in = mk(2'd0, 0, 5, 0);
    sample(); next_cycle();
    valid_in = 0;
    sample();
    checks++; if (iss_ps1_rdy !== 1'b1) begin errors++; $display("FAIL reset_busy_clear: got %b exp 1", iss_ps1_rdy); end
    next_cycle();
    alu_ready = 1;
    sample(); next_cycle();
    idle();
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      valid_in   = ($urandom_range(0, 99) < 70);
      data_in    = mk(2'($urandom_range(0, 3)), $urandom_range(0, 15),
                      $urandom_range(0, 15), $urandom_range(0, 15));
      rob_full   = ($urandom_range(0, 99) < 20);
      alu_ready  = ($urandom_range(0, 99) < 70);
      lsu_ready  = ($urandom_range(0, 99) < 70);
      br_ready   = ($urandom_range(0, 99) < 70);
      wb_valid   = ($urandom_range(0, 99) < 50);
      wb_pd      = 7'($urandom_range(0, 15));
      mispredict = ($urandom_range(0, 99) < 4);
      sample();
      checks++; if (ready_in !== e_ready_in) begin errors++;
        $display("FAIL rnd_ready_in c%0d: got %b exp %b", c, ready_in, e_ready_in); end
      checks++; if ({alu_valid, lsu_valid, br_valid} !== {e_alu_v, e_lsu_v, e_br_v}) begin errors++;
        $display("FAIL rnd_valids c%0d: got %b exp %b", c, {alu_valid, lsu_valid, br_valid}, {e_alu_v, e_lsu_v, e_br_v}); end
      checks++; if (rob_alloc !== e_fire) begin errors++;
        $display("FAIL rnd_rob_alloc c%0d: got %b exp %b", c, rob_alloc, e_fire); end
      checks++; if (iss_data !== e_data || rob_data !== e_data) begin errors++;
        $display("FAIL rnd_data c%0d: got %h/%h exp %h", c, iss_data, rob_data, e_data); end
      checks++; if ({iss_ps1_rdy, iss_ps2_rdy} !== {e_ps1, e_ps2}) begin errors++;
        $display("FAIL rnd_src_rdy c%0d: got %b exp %b", c, {iss_ps1_rdy, iss_ps2_rdy}, {e_ps1, e_ps2}); end
      next_cycle();
    end
    idle();
  endtask

  initial begin
    idle();
    model_clear();
    test_reset();
    test_alu_basic();
    test_backpressure();
    test_wb_bypass();
    test_rob_full();
    test_mispredict();
    test_set_wins_and_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
